mips_run_ctrl: RTL

//  Run-control sequencer for the MIPS pipeline. Owns instruction-memory loading,

---
 rtl/mips_run_ctrl_if.sv | 39 +++
 rtl/mips_run_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/mips_run_ctrl_if.sv
// Stimulus/datapath bundle for the MIPS run-control sequencer.
// The slave side is the sequencer; the master side is the load/debug driver and datapath.
interface mips_run_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 32
);
    logic                  i_loading;
    logic                  i_load_valid;
    logic [DATA_WIDTH-1:0] i_instruccion;
    logic [DATA_WIDTH-1:0] i_address;
    logic                  i_start;
    logic                  i_step_mode;
    logic                  i_step;
    logic                  i_halt_id;
    logic                  o_imem_we;
    logic [ADDR_WIDTH-1:0] o_imem_addr;
    logic [DATA_WIDTH-1:0] o_imem_data;
    logic                  o_pipe_enable;
    logic                  o_pipe_clear;
    logic                  o_finish;
    logic                  o_load_error;
    logic [CNT_WIDTH-1:0]  o_cycle_count;
    logic [2:0]            o_state;

    modport slave (
        input  i_loading, i_load_valid, i_instruccion, i_address,
               i_start, i_step_mode, i_step, i_halt_id,
        output o_imem_we, o_imem_addr, o_imem_data, o_pipe_enable, o_pipe_clear,
               o_finish, o_load_error, o_cycle_count, o_state
    );

    modport master (
        output i_loading, i_load_valid, i_instruccion, i_address,
               i_start, i_step_mode, i_step, i_halt_id,
        input  o_imem_we, o_imem_addr, o_imem_data, o_pipe_enable, o_pipe_clear,
               o_finish, o_load_error, o_cycle_count, o_state
    );
endinterface

// File: rtl/mips_run_ctrl.sv
// Run-control sequencer: program load, pipeline clear, free-run/single-step
// execution and HALT drain, driving the pipeline enable and completion flag.
module mips_run_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int CNT_WIDTH    = 32,
    parameter int DRAIN_CYCLES = 4
) (
    input logic            i_clock,
    input logic            i_reset,
    mips_run_ctrl_if.slave bus
);
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_CLEAR     = 3'd2,
        S_RUN       = 3'd3,
        S_STEP_WAIT = 3'd4,
        S_STEP      = 3'd5,
        S_DRAIN     = 3'd6,
        S_DONE      = 3'd7
    } state_t;

    state_t                state;
    state_t                next_state;
    logic                  start_prev;
    logic                  step_prev;
    logic                  start_edge;
    logic                  step_edge;
    logic [DRAIN_W-1:0]    drain_cnt;
    logic [CNT_WIDTH-1:0]  cycle_count;
    logic                  load_error;
    logic                  addr_in_range;
    logic                  pipe_enable;
    logic                  pipe_clear;
    logic                  vld_p1;
    logic [ADDR_WIDTH-1:0] imem_addr_p1;
    logic [DATA_WIDTH-1:0] imem_data_p1;

    assign start_edge    = bus.i_start & ~start_prev;
    assign step_edge     = bus.i_step & ~step_prev;
    assign addr_in_range = (bus.i_address[DATA_WIDTH-1:ADDR_WIDTH] == '0);

    always_comb begin
        next_state  = state;
        pipe_enable = 1'b0;
        pipe_clear  = 1'b0;
        case (state)
            S_IDLE: begin
                // Load request outranks a same-cycle start edge.
                if (bus.i_loading)   next_state = S_LOAD;
                else if (start_edge) next_state = S_CLEAR;
            end
            S_LOAD: begin
                if (!bus.i_loading) next_state = S_IDLE;
            end
            S_CLEAR: begin
                pipe_clear = 1'b1;
                next_state = bus.i_step_mode ? S_STEP_WAIT : S_RUN;
            end
            S_RUN: begin
                pipe_enable = 1'b1;
                if (bus.i_loading)        next_state = S_LOAD;
                else if (bus.i_halt_id)   next_state = S_DRAIN;
                else if (bus.i_step_mode) next_state = S_STEP_WAIT;
            end
            S_STEP_WAIT: begin
                if (bus.i_loading)         next_state = S_LOAD;
                else if (step_edge)        next_state = S_STEP;
                else if (!bus.i_step_mode) next_state = S_RUN;
            end
            S_STEP: begin
                pipe_enable = 1'b1;
                if (bus.i_loading)      next_state = S_LOAD;
                else if (bus.i_halt_id) next_state = S_DRAIN;
                else                    next_state = S_STEP_WAIT;
            end
            S_DRAIN: begin
                pipe_enable = 1'b1;
                if (bus.i_loading) next_state = S_LOAD;
                else if (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) next_state = S_DONE;
            end
            S_DONE: begin
                if (bus.i_loading)   next_state = S_LOAD;
                else if (start_edge) next_state = S_CLEAR;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state       <= S_IDLE;
            start_prev  <= 1'b0;
            step_prev   <= 1'b0;
            drain_cnt   <= '0;
            cycle_count <= '0;
            load_error  <= 1'b0;
        end else begin
            state      <= next_state;
            start_prev <= bus.i_start;
            step_prev  <= bus.i_step;
            drain_cnt  <= (state == S_DRAIN) ? drain_cnt + 1'b1 : '0;
            // Count reads zero for the whole clear pulse, then saturates.
            if (next_state == S_CLEAR)
                cycle_count <= '0;
            else if (pipe_enable && (cycle_count != '1))
                cycle_count <= cycle_count + 1'b1;
            if ((state != S_LOAD) && (next_state == S_LOAD))
                load_error <= 1'b0;
            else if ((state == S_LOAD) && bus.i_load_valid && !addr_in_range)
                load_error <= 1'b1;
        end
    end

    // Stage p1: registered instruction-memory write port
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            vld_p1       <= 1'b0;
            imem_addr_p1 <= '0;
            imem_data_p1 <= '0;
        end else begin
            vld_p1 <= (state == S_LOAD) && bus.i_load_valid && addr_in_range;
            if ((state == S_LOAD) && bus.i_load_valid && addr_in_range) begin
                imem_addr_p1 <= bus.i_address[ADDR_WIDTH-1:0];
                imem_data_p1 <= bus.i_instruccion;
            end
        end
    end

    assign bus.o_imem_we     = vld_p1;
    assign bus.o_imem_addr   = imem_addr_p1;
    assign bus.o_imem_data   = imem_data_p1;
    assign bus.o_pipe_enable = pipe_enable;
    assign bus.o_pipe_clear  = pipe_clear;
    assign bus.o_finish      = (state == S_DONE);
    assign bus.o_load_error  = load_error;
    assign bus.o_cycle_count = cycle_count;
    assign bus.o_state       = state;
endmodule
